// File: rtl/dac_setpt_engine.sv
// Multi-channel DAC setpoint engine: per-channel jump, slew-limited smooth or ramp-table
// playback on each sample tick, followed by gain/offset scaling with saturation.
module dac_setpt_engine #(
    parameter int  NUM_CH    = 4,
    parameter int  DW        = 20,
    parameter int  DEPTH     = 1024,
    parameter int  GAIN_FRAC = 17,
    parameter int  SLEW_STEP = 64,
    localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tick,
    input  logic                 wr_en,
    input  logic [CH_W-1:0]      wr_ch,
    input  logic [2:0]           wr_sel,
    input  logic [31:0]          wr_data,
    input  logic [NUM_CH-1:0]    trig,
    output logic [NUM_CH*DW-1:0] dac_data,
    output logic                 dac_valid,
    input  logic                 dac_ready,
    output logic [NUM_CH-1:0]    ramp_active,
    output logic [NUM_CH-1:0]    ramp_done,
    output logic                 overrun
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = DW + 19;
    localparam logic [17:0]          GAIN_ONE = 18'd1 << GAIN_FRAC;
    localparam logic signed [DW:0]   SLEW_P   = (DW+1)'(SLEW_STEP);
    localparam logic signed [PW-1:0] SAT_MAX  = {{(PW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [PW-1:0] SAT_MIN  = {{(PW-DW+1){1'b1}}, {(DW-1){1'b0}}};

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RD    = 3'd1,
        ST_CALC  = 3'd2,
        ST_SCALE = 3'd3,
        ST_OUT   = 3'd4
    } state_t;

    state_t                  state_r, state_s;
    logic [CH_W-1:0]         ch_r, ch_s;
    logic signed [DW-1:0]    cur_r      [NUM_CH];
    logic signed [DW-1:0]    setpoint_r [NUM_CH];
    logic signed [DW-1:0]    offset_r   [NUM_CH];
    logic [17:0]             gain_r     [NUM_CH];
    logic [1:0]              opmode_r   [NUM_CH];
    logic [AW:0]             ramplen_r  [NUM_CH];
    logic [AW-1:0]           rampaddr_r [NUM_CH];
    logic [AW-1:0]           idx_r      [NUM_CH];
    logic [NUM_CH-1:0]       ramp_active_r, ramp_done_r, start_s;
    logic [DW-1:0]           mem_r [NUM_CH*DEPTH];
    logic [DW-1:0]           rd_data_r;
    logic [NUM_CH*DW-1:0]    scaled_s, dac_data_r;
    logic                    dac_valid_r, overrun_r;

    function automatic logic signed [DW-1:0] slew_to(input logic signed [DW-1:0] cur,
                                                     input logic signed [DW-1:0] tgt);
        logic signed [DW:0] diff;
        diff = (DW+1)'(tgt) - (DW+1)'(cur);
        if (diff > SLEW_P) begin
            return cur + DW'(SLEW_STEP);
        end else if (diff < -SLEW_P) begin
            return cur - DW'(SLEW_STEP);
        end else begin
            return tgt;
        end
    endfunction

    // Product is computed wide enough that (cur * gain) never wraps before the arithmetic shift.
    function automatic logic [DW-1:0] scale_sat(input logic signed [DW-1:0] cur,
                                                input logic [17:0]          gain,
                                                input logic signed [DW-1:0] offs);
        logic signed [PW-1:0] prod;
        logic signed [PW-1:0] sum;
        prod = PW'(cur) * $signed({1'b0, gain});
        sum  = (prod >>> GAIN_FRAC) + PW'(offs);
        if (sum > SAT_MAX) begin
            return SAT_MAX[DW-1:0];
        end else if (sum < SAT_MIN) begin
            return SAT_MIN[DW-1:0];
        end else begin
            return sum[DW-1:0];
        end
    endfunction

    // Sequencer next state: one RD/CALC pair per channel, then SCALE and OUT handshake.
    always_comb begin
        state_s = state_r;
        ch_s    = ch_r;
        case (state_r)
            ST_IDLE: begin
                if (tick) begin
                    state_s = ST_RD;
                    ch_s    = '0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RD: state_s = ST_CALC;
            ST_CALC: begin
                if (ch_r == CH_W'(NUM_CH - 1)) begin
                    state_s = ST_SCALE;
                end else begin
                    state_s = ST_RD;
                    ch_s    = ch_r + CH_W'(1'b1);
                end
            end
            ST_SCALE: state_s = ST_OUT;
            ST_OUT: begin
                if (dac_ready) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_OUT;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Sequencer state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
            ch_r    <= '0;
        end else begin
            state_r <= state_s;
            ch_r    <= ch_s;
        end
    end

    // Ramp start requests, only honoured in smooth/ramp mode with a non-empty table.
    always_comb begin
        start_s = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            start_s[i] = (trig[i] | (wr_en & (wr_sel == 3'd5) & (wr_ch == CH_W'(i)) & wr_data[0]))
                         & (opmode_r[i] == 2'd0) & (ramplen_r[i] != '0);
        end
    end

    // Ramp table: write port from register decode, registered read port used in RD.
    always_ff @(posedge clk) begin
        if (wr_en && (wr_sel == 3'd4)) begin
            mem_r[{wr_ch, rampaddr_r[wr_ch]}] <= wr_data[DW-1:0];
        end
        if (state_r == ST_RD) begin
            rd_data_r <= mem_r[{ch_r, idx_r[ch_r]}];
        end
    end

    // Per-channel registers: CALC update first, then ramp starts, then register writes win.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                cur_r[i]      <= '0;
                setpoint_r[i] <= '0;
                offset_r[i]   <= '0;
                gain_r[i]     <= GAIN_ONE;
                opmode_r[i]   <= 2'd0;
                ramplen_r[i]  <= '0;
                rampaddr_r[i] <= '0;
                idx_r[i]      <= '0;
            end
            ramp_active_r <= '0;
            ramp_done_r   <= '0;
        end else begin
            ramp_done_r <= '0;
            if (state_r == ST_CALC) begin
                case (opmode_r[ch_r])
                    2'd3: cur_r[ch_r] <= setpoint_r[ch_r];
                    2'd0: begin
                        if (ramp_active_r[ch_r]) begin
                            cur_r[ch_r] <= rd_data_r;
                            idx_r[ch_r] <= idx_r[ch_r] + AW'(1'b1);
                            if ({1'b0, idx_r[ch_r]} == ramplen_r[ch_r] - (AW+1)'(1'b1)) begin
                                ramp_active_r[ch_r] <= 1'b0;
                                ramp_done_r[ch_r]   <= 1'b1;
                                setpoint_r[ch_r]    <= rd_data_r;
                            end
                        end else begin
                            cur_r[ch_r] <= slew_to(cur_r[ch_r], setpoint_r[ch_r]);
                        end
                    end
                    default: cur_r[ch_r] <= cur_r[ch_r];
                endcase
            end
            for (int i = 0; i < NUM_CH; i++) begin
                if (start_s[i]) begin
                    ramp_active_r[i] <= 1'b1;
                    idx_r[i]         <= '0;
                end
            end
            if (wr_en) begin
                case (wr_sel)
                    3'd0: setpoint_r[wr_ch] <= wr_data[DW-1:0];
                    3'd1: begin
                        opmode_r[wr_ch] <= wr_data[1:0];
                        if (wr_data[1:0] != 2'd0) begin
                            ramp_active_r[wr_ch] <= 1'b0;
                        end
                    end
                    3'd2: ramplen_r[wr_ch]  <= (wr_data > 32'(DEPTH)) ? (AW+1)'(DEPTH) : wr_data[AW:0];
                    3'd3: rampaddr_r[wr_ch] <= wr_data[AW-1:0];
                    3'd4: rampaddr_r[wr_ch] <= rampaddr_r[wr_ch] + AW'(1'b1);
                    3'd6: gain_r[wr_ch]     <= wr_data[17:0];
                    3'd7: offset_r[wr_ch]   <= wr_data[DW-1:0];
                    default: ;
                endcase
            end
        end
    end

    // Scale and saturate every channel in parallel for the SCALE cycle.
    always_comb begin
        scaled_s = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            scaled_s[i*DW +: DW] = scale_sat(cur_r[i], gain_r[i], offset_r[i]);
        end
    end

    // Output word, valid handshake and sticky overrun flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dac_data_r  <= '0;
            dac_valid_r <= 1'b0;
            overrun_r   <= 1'b0;
        end else begin
            if (tick && (state_r != ST_IDLE)) begin
                overrun_r <= 1'b1;
            end
            if (state_r == ST_SCALE) begin
                dac_data_r  <= scaled_s;
                dac_valid_r <= 1'b1;
            end else if ((state_r == ST_OUT) && dac_ready) begin
                dac_valid_r <= 1'b0;
            end
        end
    end

    assign dac_data    = dac_data_r;
    assign dac_valid   = dac_valid_r;
    assign ramp_active = ramp_active_r;
    assign ramp_done   = ramp_done_r;
    assign overrun     = overrun_r;
endmodule

// File: tb/tb_dac_setpt_engine.sv
// Self-checking bench for dac_setpt_engine: directed steps plus a randomized phase,
// compared against a per-channel behavioural model of the setpoint rules.
module tb_dac_setpt_engine;
    localparam int NUM_CH = 4, DW = 20, DEPTH = 1024, GAIN_FRAC = 17, SLEW_STEP = 64;

    logic                 clk = 1'b0;
    logic                 reset, tick, wr_en, dac_ready, dac_valid, overrun;
    logic [1:0]           wr_ch;
    logic [2:0]           wr_sel;
    logic [31:0]          wr_data;
    logic [NUM_CH-1:0]    trig, ramp_active, ramp_done, done_seen, m_done;
    logic [NUM_CH*DW-1:0] dac_data;
    int errors = 0, checks = 0;

    int m_cur[NUM_CH], m_sp[NUM_CH], m_off[NUM_CH], m_gain[NUM_CH], m_op[NUM_CH];
    int m_len[NUM_CH], m_addr[NUM_CH], m_idx[NUM_CH];
    bit m_act[NUM_CH];
    int m_tab[NUM_CH][DEPTH];

    dac_setpt_engine dut (
        .clk(clk), .reset(reset), .tick(tick), .wr_en(wr_en), .wr_ch(wr_ch),
        .wr_sel(wr_sel), .wr_data(wr_data), .trig(trig), .dac_data(dac_data),
        .dac_valid(dac_valid), .dac_ready(dac_ready), .ramp_active(ramp_active),
        .ramp_done(ramp_done), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int sx(input int v);
        int u;
        u = v & 'hFFFFF;
        if (u >= 'h80000) u = u - 'h100000;
        return u;
    endfunction

    function automatic logic [DW-1:0] exp_out(input int ch);
        longint p;
        p = longint'(m_cur[ch]) * longint'(m_gain[ch]);
        p = (p >>> GAIN_FRAC) + longint'(m_off[ch]);
        if (p > 524287) p = 524287;
        if (p < -524288) p = -524288;
        return p[DW-1:0];
    endfunction

    function automatic logic [NUM_CH-1:0] act_mask();
        logic [NUM_CH-1:0] m;
        for (int c = 0; c < NUM_CH; c++) m[c] = m_act[c];
        return m;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            m_cur[c] = 0; m_sp[c] = 0; m_off[c] = 0; m_gain[c] = 1 << GAIN_FRAC;
            m_op[c] = 0; m_len[c] = 0; m_addr[c] = 0; m_idx[c] = 0; m_act[c] = 0;
        end
    endtask

    task automatic model_start(input int ch);
        if (m_op[ch] == 0 && m_len[ch] != 0) begin
            m_act[ch] = 1;
            m_idx[ch] = 0;
        end
    endtask

    task automatic model_tick();
        int d;
        m_done = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (m_op[c] == 3) begin
                m_cur[c] = m_sp[c];
            end else if (m_op[c] == 0 && m_act[c]) begin
                m_cur[c] = m_tab[c][m_idx[c]];
                if (m_idx[c] == m_len[c] - 1) begin
                    m_act[c] = 0;
                    m_done[c] = 1'b1;
                    m_sp[c] = m_cur[c];
                end
                m_idx[c] = (m_idx[c] + 1) % DEPTH;
            end else if (m_op[c] == 0) begin
                d = m_sp[c] - m_cur[c];
                if (d > SLEW_STEP) m_cur[c] += SLEW_STEP;
                else if (d < -SLEW_STEP) m_cur[c] -= SLEW_STEP;
                else m_cur[c] = m_sp[c];
            end
        end
    endtask

    task automatic wr(input int ch, input int sel, input int data);
        @(negedge clk);
        wr_en = 1'b1; wr_ch = ch[1:0]; wr_sel = sel[2:0]; wr_data = data;
        @(negedge clk);
        wr_en = 1'b0;
        case (sel)
            0: m_sp[ch] = sx(data);
            1: begin
                m_op[ch] = data & 3;
                if (m_op[ch] != 0) m_act[ch] = 0;
            end
            2: m_len[ch] = (data > DEPTH || data < 0) ? DEPTH : data;
            3: m_addr[ch] = data & (DEPTH - 1);
            4: begin
                m_tab[ch][m_addr[ch]] = sx(data);
                m_addr[ch] = (m_addr[ch] + 1) % DEPTH;
            end
            5: if ((data & 1) != 0) model_start(ch);
            6: m_gain[ch] = data & 'h3FFFF;
            7: m_off[ch] = sx(data);
            default: ;
        endcase
    endtask

    task automatic pulse_trig(input int ch);
        @(negedge clk);
        trig = '0;
        trig[ch] = 1'b1;
        @(negedge clk);
        trig = '0;
        model_start(ch);
    endtask

    task automatic release_dac();
        @(negedge clk);
        dac_ready = 1'b1;
        @(posedge clk);
        #1 dac_ready = 1'b0;
        chk("valid_drop", dac_valid, 1'b0);
    endtask

    task automatic run_tick(input bit rel);
        int n;
        @(negedge clk);
        tick = 1'b1;
        @(posedge clk);
        #1 tick = 1'b0;
        n = 1;
        done_seen = '0;
        while (!dac_valid && n < 40) begin
            @(posedge clk);
            #1;
            n++;
            done_seen |= ramp_done;
        end
        model_tick();
        chk("latency", n, 2 * NUM_CH + 2);
        for (int c = 0; c < NUM_CH; c++)
            chk($sformatf("dac_ch%0d", c), dac_data[c*DW +: DW], exp_out(c));
        chk("ramp_done", done_seen, m_done);
        chk("ramp_active", ramp_active, act_mask());
        if (rel) release_dac();
    endtask

    initial begin
        int ch, k;
        reset = 1'b1; tick = 1'b0; wr_en = 1'b0; wr_ch = '0; wr_sel = '0; wr_data = '0;
        trig = '0; dac_ready = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_valid", dac_valid, 1'b0);
        chk("rst_data", dac_data, '0);
        chk("rst_active", ramp_active, '0);
        chk("rst_done", ramp_done, '0);
        chk("rst_overrun", overrun, 1'b0);

        // Jump on channel 0
        wr(0, 7, 'h20); wr(0, 1, 3); wr(0, 0, 'h1234);
        run_tick(1'b0);
        chk("jump_ch0", dac_data[DW-1:0], 20'h01254);
        release_dac();

        // Slew-limited smooth approach on channel 1
        wr(1, 0, 1000);
        for (int t = 1; t <= 17; t++) begin
            run_tick(1'b0);
            chk("smooth_ch1", dac_data[DW +: DW], 20'((t * 64 > 1000) ? 1000 : t * 64));
            release_dac();
        end

        // Ramp table playback on channel 2 via auto-increment loading
        wr(2, 2, 10); wr(2, 3, 0);
        for (int v = 10; v < 20; v++) wr(2, 4, v);
        wr(2, 5, 1);
        chk("ramp_start", ramp_active[2], 1'b1);
        for (int t = 0; t < 10; t++) begin
            run_tick(1'b0);
            chk("ramp_val", dac_data[2*DW +: DW], 20'(10 + t));
            release_dac();
        end
        chk("ramp_done_19", done_seen[2], 1'b1);
        run_tick(1'b0);
        chk("ramp_hold", dac_data[2*DW +: DW], 20'd19);
        release_dac();

        // Abort mid-ramp by switching to jump, then trig ignored in jump mode
        wr(2, 5, 1);
        for (int t = 0; t < 3; t++) run_tick(1'b1);
        wr(2, 1, 3);
        chk("abort_active", ramp_active[2], 1'b0);
        run_tick(1'b1);
        wr(2, 0, 500);
        run_tick(1'b0);
        chk("abort_jump", dac_data[2*DW +: DW], 20'd500);
        release_dac();
        pulse_trig(2);
        chk("trig_ignored", ramp_active[2], 1'b0);

        // Zero-length start ignored; rampaddr wraps modulo DEPTH
        wr(3, 5, 1);
        chk("len0_ignored", ramp_active[3], 1'b0);
        wr(3, 3, DEPTH - 1); wr(3, 4, 77); wr(3, 4, 88);
        wr(3, 2, 1); pulse_trig(3);
        run_tick(1'b0);
        chk("addr_wrap", dac_data[3*DW +: DW], 20'd88);
        release_dac();

        // Saturation at both rails
        wr(3, 6, 'h3FFFF); wr(3, 1, 3); wr(3, 0, 'h7FFFF);
        run_tick(1'b0);
        chk("sat_pos", dac_data[3*DW +: DW], 20'h7FFFF);
        release_dac();
        wr(3, 0, 'h80000);
        run_tick(1'b0);
        chk("sat_neg", dac_data[3*DW +: DW], 20'h80000);

        // Tick while output is held: dropped, overrun set, data stable
        @(negedge clk) tick = 1'b1;
        @(negedge clk) tick = 1'b0;
        repeat (4) @(negedge clk);
        chk("overrun", overrun, 1'b1);
        chk("held_valid", dac_valid, 1'b1);
        for (int c = 0; c < NUM_CH; c++) chk("held_data", dac_data[c*DW +: DW], exp_out(c));
        release_dac();

        // Randomized register traffic and ticks
        for (int c = 0; c < NUM_CH; c++) begin
            wr(c, 1, 1);
            wr(c, 3, 0);
            for (int e = 0; e < 8; e++) wr(c, 4, $urandom);
        end
        for (int it = 0; it < 30; it++) begin
            ch = $urandom_range(NUM_CH - 1, 0);
            k = $urandom_range(6, 0);
            case (k)
                0: wr(ch, 0, $urandom);
                1: wr(ch, 1, $urandom_range(3, 0));
                2: wr(ch, 6, $urandom_range('h3FFFF, 0));
                3: wr(ch, 7, $urandom_range(4095, 0) - 2048);
                4: begin
                    wr(ch, 1, 0);
                    if (!m_act[ch]) wr(ch, 2, $urandom_range(8, 1));
                    wr(ch, 5, 1);
                end
                5: if (m_len[ch] != 0 && m_len[ch] <= 8) pulse_trig(ch);
                default: wr(ch, 1, 0);
            endcase
            run_tick(1'b1);
        end

        // Asynchronous reset while the output word is held
        run_tick(1'b0);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_valid", dac_valid, 1'b0);
        chk("async_rst_overrun", overrun, 1'b0);
        @(negedge clk) reset = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
